// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver with a double-buffered load,
// leading-zero blanking, inter-digit anti-ghost gap and PWM brightness.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SLOT_CYCLES  = 16384,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned PWM_BITS     = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [4*NUM_DIGITS-1:0] x,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic                    pending,
  output logic                    frame_start,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned CntW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] SlotLast = CntW'(SLOT_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);

  logic [CntW-1:0]         slot_cnt_q, slot_cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_x_q, active_x_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, active_dp_q;
  logic [NUM_DIGITS-1:0]   shadow_en_q, active_en_q;
  logic                    pending_q, pending_d;
  logic                    frame_start_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic       slot_wrap, frame_wrap;
  logic [3:0] cur_digit;
  logic       cur_dp, cur_en, cur_blank, all_zero, lit;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7F;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_wrap  = (slot_cnt_q == SlotLast);
    frame_wrap = slot_wrap && (idx_q == IdxLast);
    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    // A load on the boundary edge keeps pending set for the next frame.
    pending_d = pending_q;
    if (frame_wrap) pending_d = 1'b0;
    if (load)       pending_d = 1'b1;
  end

  // Walk from the top digit down so all_zero covers digit i and everything above it.
  always_comb begin
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blank = 1'b0;
    all_zero  = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      all_zero = all_zero & (active_x_q[4*i +: 4] == 4'h0);
      if (idx_q == IdxW'(i)) begin
        cur_digit = active_x_q[4*i +: 4];
        cur_dp    = active_dp_q[i];
        cur_en    = active_en_q[i];
        cur_blank = blank_lz && all_zero && (i != 0);
      end
    end
  end

  always_comb begin
    lit = (slot_cnt_q >= BlankEnd) && (slot_cnt_q[PWM_BITS-1:0] <= brightness) &&
          cur_en && !cur_blank;
    an_d = '1;
    if (lit) an_d[idx_q] = 1'b0;
    seg_d = lit ? hex_decode(cur_digit) : 7'h7F;
    dp_d  = lit ? ~cur_dp : 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      slot_cnt_q    <= '0;
      idx_q         <= '0;
      shadow_x_q    <= '0;
      shadow_dp_q   <= '0;
      shadow_en_q   <= '0;
      active_x_q    <= '0;
      active_dp_q   <= '0;
      active_en_q   <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= '1;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      if (load) begin
        shadow_x_q  <= x;
        shadow_dp_q <= dp_in;
        shadow_en_q <= digit_en;
      end
      if (frame_wrap && pending_q) begin
        active_x_q  <= shadow_x_q;
        active_dp_q <= shadow_dp_q;
        active_en_q <= shadow_en_q;
      end
      pending_q     <= pending_d;
      frame_start_q <= frame_wrap;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign pending     = pending_q;
  assign frame_start = frame_start_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;

endmodule
